mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Memory stage directly downstream of the EX ALU. Takes the ALU result as a byte address (or as a
//  plain result when no memory op), issues one request on a req/gnt/rvalid data-memory bus,
//  aligns/extends load data and returns a single-cycle response to writeback.
//  Holds the core via busy while a transaction is outstanding.
// PARAMETERS
//  DATA_WIDTH  32  datapath width (= ALU_DATA_WIDTH); fixed at 32, byte lanes = 4
//  ADDR_WIDTH  32  byte address width (= ALU_DATA_WIDTH)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   EX presents an instruction
//  req_ready    out  1   1 only in IDLE; accept = req_valid & req_ready
//  mem_read     in   1   load
//  mem_write    in   1   store
//  funct3       in   3   RISC-V width/sign code
//  alu_result   in   32  byte address, or pass-through result
//  store_data   in   32  rs2 value
//  busy         out  1   state != IDLE
//  resp_valid   out  1   one-cycle pulse: result ready for writeback
//  resp_data    out  32  extended load data / pass-through alu_result / 0 on fault
//  misaligned   out  1   qualified by resp_valid
//  illegal      out  1   qualified by resp_valid
//  dmem_req     out  1   bus request, held until dmem_gnt
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  {alu_result[31:2],2'b00}
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_wstrb   out  4   byte enables (0 for reads)
//  dmem_gnt     in   1   request accepted this cycle
//  dmem_rvalid  in   1   read data valid (>=1 cycle after gnt)
//  dmem_rdata   in   32  aligned word
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except req_ready=1. All outputs registered.
//  Reset mid-transaction: abandon it; dmem_req=0 next cycle; later dmem_rvalid ignored.
//  FSM IDLE->REQ->(WAIT)->DONE->IDLE. All fields latched on accept.
//   IDLE: on accept, classify:
//    - mem_read & mem_write -> illegal.
//    - load funct3 not in {000,001,010,100,101} or store funct3 not in {000,001,010} -> illegal.
//    - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> misaligned.
//    - Fault (illegal wins if both): go to DONE; no bus access; resp_data=0.
//    - Neither read nor write: go to DONE; resp_data=alu_result.
//    - Otherwise go to REQ.
//   REQ: dmem_req=1, fields stable until gnt.
//    - gnt on store -> DONE. gnt on load -> WAIT.
//   WAIT: dmem_req=0; on dmem_rvalid capture rdata -> DONE.
//   DONE: resp_valid=1 for exactly one cycle -> IDLE. req_ready returns 1 in IDLE.
//  Latency from accept cycle T:
//   - Pass-through/fault resp at T+1.
//   - Store with immediate gnt resp at T+2.
//   - Load with gnt at T+1 and rvalid at T+2 resp at T+3.
//  Store lanes (a=addr[1:0]):
//   - SB: wstrb=4'b0001<<a, wdata={4{sd[7:0]}}.
//   - SH: wstrb=4'b0011<<a, wdata={2{sd[15:0]}}.
//   - SW: 4'b1111, sd.
//  Load: byte=rdata[8a+:8], half=rdata[16a[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW word.
//  dmem_rvalid outside WAIT and dmem_gnt outside REQ are ignored.
//  req_valid while busy is not accepted; upstream holds.
// TESTING
//  1. Pass-through: rd=wr=0, alu_result=0x0000_1234 -> resp_valid at T+1, resp_data=0x1234, no dmem_req.
//  2. SB addr 0x103, sd 0x0000_00A5 -> dmem_addr=0x100, wstrb=1000, wdata=0xA5A5_A5A5; gnt after 3 cycles -> resp 1 cycle later.
//  3. LB addr 0x102, rdata 0x0080_0000 -> resp_data=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr 0x102, rdata 0x8001_0000 -> 0xFFFF_8001.
//  4. LW addr 0x206 -> misaligned=1, resp_data=0, dmem_req never 1. funct3=011 load -> illegal=1.
//  5. rst=1 in WAIT, then rvalid pulse -> no resp_valid, state IDLE, req_ready=1 next cycle.
//  6. Back-to-back: SW then LW to same addr, stub memory -> load returns stored word; req_ready low throughout each op.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage after the EX ALU: one req/gnt/rvalid data-memory transaction per accepted
// instruction, with store lane steering, load alignment/extension and a one-cycle response.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;

  logic            ill_c;
  logic            mis_c;
  logic [3:0]      strb_c;
  logic [31:0]     wdata_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [31:0]     load_c;

  // Classification and store lane steering of the instruction currently presented by EX.
  always_comb begin
    ill_c   = 1'b0;
    mis_c   = 1'b0;
    strb_c  = 4'b1111;
    wdata_c = store_data;
    if (mem_read && mem_write) begin
      ill_c = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill_c = 1'b0;
        default:                                ill_c = 1'b1;
      endcase
    end else if (mem_write) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: ill_c = 1'b0;
        default:                ill_c = 1'b1;
      endcase
    end
    if (mem_read || mem_write) begin
      case (funct3[1:0])
        2'b01:   mis_c = alu_result[0];
        2'b10:   mis_c = |alu_result[1:0];
        default: mis_c = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << alu_result[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << alu_result[1:0];
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Load data selection uses the funct3/offset latched at accept, not the live inputs.
  always_comb begin
    byte_c = dmem_rdata[{lane_q, 3'b000} +: 8];
    half_c = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      f3_q       <= '0;
      lane_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            f3_q      <= funct3;
            lane_q    <= alu_result[1:0];
            if (ill_c || mis_c) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= '0;
              illegal    <= ill_c;
              misaligned <= mis_c & ~ill_c;
            end else if (!mem_read && !mem_write) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= alu_result;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
              dmem_wdata <= mem_write ? wdata_c : '0;
              dmem_wstrb <= mem_write ? strb_c : 4'b0000;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= load_c;
          end
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          misaligned <= 1'b0;
          illegal    <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
